// File: rtl/bidi_shift_serializer.sv
// bidi_shift_serializer: 4-bit parallel-to-serial converter, LSB- or MSB-first per word.
// Define SERIALIZER_PARITY_EN to append an even-parity bit (5-bit frame).
module bidi_shift_serializer (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d_in,
  input  logic       load,
  input  logic       shiftR,
  output logic       ready,
  output logic       d_out,
  output logic       sout_valid,
  output logic       done
);

`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif
  localparam int               CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;   // index of the frame bit currently on d_out
  logic [3:0]       sreg;      // data bits not yet presented
  logic             dir_r;     // captured shiftR: 1 = LSB first
`ifdef SERIALIZER_PARITY_EN
  logic             parity;
`endif
  logic             accept;
  logic             next_bit;

  assign done   = (state == SHIFT) && (bit_cnt == LAST_IDX);
  // ready is gated by reset so it drops immediately on assertion, not at the next edge.
  assign ready  = reset && ((state == IDLE) || done);
  assign accept = load && ready;

  // NOTE: next_bit gets a value on every path first, so no latch is inferred.
  always_comb begin
    next_bit = dir_r ? sreg[0] : sreg[3];
`ifdef SERIALIZER_PARITY_EN
    if (bit_cnt == LAST_IDX - 1'b1) next_bit = parity;
`endif
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      sreg       <= '0;
      dir_r      <= 1'b0;
      d_out      <= 1'b0;
      sout_valid <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity     <= 1'b0;
`endif
    end else if (accept) begin
      // First bit goes straight to d_out; the rest wait in sreg.
      state      <= SHIFT;
      bit_cnt    <= '0;
      dir_r      <= shiftR;
      d_out      <= shiftR ? d_in[0] : d_in[3];
      sreg       <= shiftR ? {1'b0, d_in[3:1]} : {d_in[2:0], 1'b0};
      sout_valid <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
      parity     <= ^d_in;
`endif
    end else if (state == SHIFT) begin
      if (done) begin
        state      <= IDLE;
        bit_cnt    <= '0;
        sreg       <= '0;
        d_out      <= 1'b0;
        sout_valid <= 1'b0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
        d_out   <= next_bit;
        sreg    <= dir_r ? {1'b0, sreg[3:1]} : {sreg[2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_bidi_shift_serializer.sv
// tb_bidi_shift_serializer: directed and random stimulus against a queue-of-bits reference model.
// Build with SERIALIZER_PARITY_EN defined to exercise the parity frame.
module tb_bidi_shift_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int          FL  = 5;
  localparam logic [15:0] E27 = 16'b11011;
  localparam logic [15:0] E28 = 16'b10111;
  localparam logic [15:0] E29 = 16'b1000110001;
`else
  localparam int          FL  = 4;
  localparam logic [15:0] E27 = 16'b1101;
  localparam logic [15:0] E28 = 16'b1011;
  localparam logic [15:0] E29 = 16'b10001000;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] d_in = '0;
  logic       load = 1'b0;
  logic       shiftR = 1'b0;
  logic       ready, d_out, sout_valid, done;

  int          vectors = 0;
  int          miscompares = 0;
  bit          q[$];          // expected bits: q[0] is on d_out now
  logic [15:0] got_bits;
  int          nvalid;

  bidi_shift_serializer dut (
    .clk(clk), .reset(reset), .d_in(d_in), .load(load), .shiftR(shiftR),
    .ready(ready), .d_out(d_out), .sout_valid(sout_valid), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] obs();
    return {12'b0, d_out, sout_valid, done, ready};
  endfunction

  // Outputs follow directly from the pending-bit queue: last bit => done and ready.
  function automatic logic [15:0] model_outs();
    if (!reset) return 16'h0000;
    if (q.size() == 0) return 16'h0001;
    return {12'b0, q[0], 1'b1, 1'(q.size() == 1), 1'(q.size() == 1)};
  endfunction

  task automatic push_frame(input logic [3:0] w, input logic r);
    for (int i = 0; i < 4; i++) q.push_back(r ? w[i] : w[3-i]);
`ifdef SERIALIZER_PARITY_EN
    q.push_back(^w);
`endif
  endtask

  // Called just after a falling edge: check this cycle, drive inputs, advance the model.
  task automatic cycle(input logic ld, input logic [3:0] w, input logic r, input string tag);
    logic acc;
    check(tag, obs(), model_outs());
    if (sout_valid) begin
      got_bits = {got_bits[14:0], d_out};
      nvalid++;
    end
    load = ld; d_in = w; shiftR = r;
    acc = ld && (q.size() <= 1);
    @(posedge clk);
    if (q.size() > 0) q.delete(0);
    if (acc) push_frame(w, r);
    @(negedge clk);
    #1;
  endtask

  task automatic idle_cycle(input string tag);
    cycle(1'b0, 4'($urandom), 1'($urandom), tag);
  endtask

  task automatic clear_log();
    got_bits = '0;
    nvalid = 0;
  endtask

  initial begin
    #12;
    check("reset_state", obs(), 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ready_after_reset", {15'b0, ready}, 16'h0001);

    // LSB-first frame of 1011
    clear_log();
    cycle(1'b1, 4'b1011, 1'b1, "t27");
    repeat (FL) idle_cycle("t27");
    idle_cycle("t27_idle");
    check("t27_bits", got_bits, E27);
    check("t27_len", 16'(nvalid), 16'(FL));

    // MSB-first frame of 1011
    clear_log();
    cycle(1'b1, 4'b1011, 1'b0, "t28");
    repeat (FL) idle_cycle("t28");
    idle_cycle("t28_idle");
    check("t28_bits", got_bits, E28);

    // Back-to-back: second load lands in the done cycle
    clear_log();
    cycle(1'b1, 4'b0001, 1'b1, "t29");
    repeat (FL - 1) idle_cycle("t29");
    cycle(1'b1, 4'b1000, 1'b0, "t29_reload");
    repeat (FL) idle_cycle("t29");
    idle_cycle("t29_idle");
    check("t29_bits", got_bits, E29);
    check("t29_len", 16'(nvalid), 16'(2 * FL));

    // Load while busy must be ignored
    clear_log();
    cycle(1'b1, 4'b0000, 1'b1, "t30");
    idle_cycle("t30");
    cycle(1'b1, 4'b1111, 1'b0, "t30_busy_load");
    repeat (FL - 2) idle_cycle("t30");
    idle_cycle("t30_idle");
    check("t30_bits", got_bits, 16'h0000);
    check("t30_len", 16'(nvalid), 16'(FL));

`ifdef SERIALIZER_PARITY_EN
    clear_log();
    cycle(1'b1, 4'b0111, 1'b1, "t32");
    repeat (FL) idle_cycle("t32");
    idle_cycle("t32_idle");
    check("t32_bits", got_bits, 16'b11101);
`endif

    // Asynchronous reset in the middle of bit 2
    cycle(1'b1, 4'b1010, 1'b0, "t31");
    idle_cycle("t31");
    #1 reset = 1'b0;
    load = 1'b0;
    #1 check("t31_async", obs(), 16'h0000);
    q.delete();
    @(posedge clk);
    #1 check("t31_held", obs(), 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t31_ready", {15'b0, ready}, 16'h0001);
    repeat (FL + 1) idle_cycle("t31_after");

    // Random traffic with a high load rate
    for (int n = 0; n < 400; n++)
      cycle(1'($urandom_range(0, 2) != 0), 4'($urandom), 1'($urandom), "rand");

    // Drain
    repeat (FL + 1) idle_cycle("drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
